button_event_arbiter: RTL

- Sits between the per-button debouncer instances and the game-control FSM.
- Turns NUM_BTN debounced button levels into discrete press and long-press events.
- Holds at most one pending event per button and hands them to the single game-FSM consumer.
- Consumer interface is a valid/ready handshake with round-robin fairness.

---
 rtl/button_event_arbiter_if.sv | 12 +
 rtl/button_event_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/button_event_arbiter_if.sv
// Event handshake between the button event arbiter and the game-control FSM.
interface button_event_arbiter_if #(
  parameter int unsigned ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_long;

  modport master (output evt_valid, output evt_id, output evt_long, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_long, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// Converts debounced button levels into press / long-press events, buffers one
// pending event per button and serves them round-robin over a valid/ready port.
module button_event_arbiter #(
  parameter int unsigned NUM_BTN           = 4,
  parameter int unsigned ID_W              = 2,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter int unsigned CNT_W             = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BTN-1:0]     btn_level,
  button_event_arbiter_if.master evt,
  output logic [NUM_BTN-1:0]     pending,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [NUM_BTN-1:0] btn_prev;
  logic [NUM_BTN-1:0] armed;
  logic [NUM_BTN-1:0] long_fired;
  logic [NUM_BTN-1:0] slot_long;
  logic [CNT_W-1:0]   hold_cnt [NUM_BTN];
  logic [ID_W-1:0]    rr_ptr;

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] long_ev;
  logic [NUM_BTN-1:0] drain;
  logic [NUM_BTN-1:0] ovf_set;
  logic               load;
  logic               sel_found;
  logic [ID_W-1:0]    sel_idx;
  logic [ID_W-1:0]    scan_idx;
  int unsigned        scan_sum;

  // Event detection and round-robin selection over the pending slots
  always_comb begin
    press     = btn_level & ~btn_prev;
    long_ev   = '0;
    drain     = '0;
    ovf_set   = '0;
    load      = ~evt.evt_valid | evt.evt_ready;
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    scan_sum  = 0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      long_ev[i] = btn_level[i] & armed[i] & ~press[i] & ~long_fired[i] &
                   (hold_cnt[i] == CNT_MAX);
    end
    for (int unsigned k = 0; k < NUM_BTN; k++) begin
      scan_sum = 32'(rr_ptr) + k;
      if (scan_sum >= NUM_BTN) scan_sum = scan_sum - NUM_BTN;
      scan_idx = ID_W'(scan_sum);
      if (!sel_found && pending[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      drain[i]   = load & sel_found & (sel_idx == ID_W'(i));
      ovf_set[i] = (press[i] | long_ev[i]) & pending[i] & ~drain[i];
    end
  end

  // Per-button edge tracking, hold counters and pending slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev   <= '1;
      armed      <= '0;
      long_fired <= '0;
      pending    <= '0;
      slot_long  <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) hold_cnt[i] <= '0;
    end else begin
      btn_prev <= btn_level;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        // A button held through reset stays unarmed until it is seen released
        if (!btn_level[i]) armed[i] <= 1'b1;

        if (press[i] || !btn_level[i])              hold_cnt[i] <= '0;
        else if (armed[i] && hold_cnt[i] != CNT_MAX) hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);

        if (!btn_level[i])   long_fired[i] <= 1'b0;
        else if (long_ev[i]) long_fired[i] <= 1'b1;

        if (press[i] || long_ev[i]) begin
          pending[i]   <= 1'b1;
          slot_long[i] <= long_ev[i];
        end else if (drain[i]) begin
          pending[i]   <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow: a new overwrite beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (|ovf_set)     overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt.evt_valid <= 1'b0;
      evt.evt_id    <= '0;
      evt.evt_long  <= 1'b0;
      rr_ptr        <= '0;
    end else if (load) begin
      if (sel_found) begin
        evt.evt_valid <= 1'b1;
        evt.evt_id    <= sel_idx;
        evt.evt_long  <= slot_long[sel_idx];
        rr_ptr        <= (sel_idx == ID_W'(NUM_BTN - 1)) ? '0 : sel_idx + ID_W'(1);
      end else begin
        evt.evt_valid <= 1'b0;
      end
    end
  end

endmodule
